// File: rtl/axi_lite_protocol_monitor.sv
// axi_lite_protocol_monitor: passive AXI-Lite checker with sticky violation flags and first-error capture
module axi_lite_protocol_monitor #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid,
  input  logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [2:0]          aw_prot,
  input  logic                w_valid,
  input  logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                b_valid,
  input  logic                b_ready,
  input  logic [1:0]          b_resp,
  input  logic                ar_valid,
  input  logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [2:0]          ar_prot,
  input  logic                r_valid,
  input  logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                err_clear,
  output logic [15:0]         err_flags,
  output logic                err_any,
  output logic [3:0]          first_err,
  output logic [3:0]          wr_outst,
  output logic [3:0]          rd_outst
);
  localparam int PA = ADDR_W + 3;
  localparam int PD = DATA_W + DATA_W / 8 + 2;
  localparam int PW = PA > PD ? PA : PD;
  localparam int TW = TIMEOUT < 1 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0] MX = 4'(MAX_OUTST);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [4:0] v, rdy, st_q;
  logic [PW-1:0] pl [5];
  logic [PW-1:0] cap [5];
  logic [9:0] stab;
  logic [15:0] viol;
  logic [3:0] aw_cnt, w_cnt, rd_cnt;
  logic [TW-1:0] wt, rt;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_bad, b_dec, r_bad, r_dec, aw_ovf, w_ovf, ar_ovf, wt_viol, rt_viol;
  assign v     = {r_valid, ar_valid, b_valid, w_valid, aw_valid};
  assign rdy   = {r_ready, ar_ready, b_ready, w_ready, aw_ready};
  assign pl[0] = PW'({aw_addr, aw_prot});
  assign pl[1] = PW'({w_data, w_strb});
  assign pl[2] = PW'(b_resp);
  assign pl[3] = PW'({ar_addr, ar_prot});
  assign pl[4] = PW'({r_data, r_resp});
  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;
  assign b_hs  = b_valid & b_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign r_hs  = r_valid & r_ready;
  // a response is only legal once both address and data of a write have been accepted
  assign b_bad  = b_hs & (aw_cnt == 4'd0 | w_cnt == 4'd0);
  assign b_dec  = b_hs & !b_bad;
  assign r_bad  = r_hs & rd_cnt == 4'd0;
  assign r_dec  = r_hs & !r_bad;
  assign aw_ovf = aw_hs & !b_dec & aw_cnt == MX;
  assign w_ovf  = w_hs & !b_dec & w_cnt == MX;
  assign ar_ovf = ar_hs & !r_dec & rd_cnt == MX;
  // fires only on the cycle the timer steps onto TIMEOUT, so each stall reports once
  assign wt_viol = TIMEOUT != 0 && aw_cnt != 4'd0 && !b_hs && wt == TLAST;
  assign rt_viol = TIMEOUT != 0 && rd_cnt != 4'd0 && !r_hs && rt == TLAST;
  always_comb begin
    stab = '0;
    for (int i = 0; i < 5; i++) begin
      stab[2*i]   = st_q[i] & !v[i];
      stab[2*i+1] = st_q[i] & v[i] & (pl[i] != cap[i]);
    end
  end
  assign viol = {rt_viol, wt_viol, ar_ovf, aw_ovf | w_ovf, r_bad, b_bad, stab};
  function automatic logic [3:0] lowest(input logic [15:0] x);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) if (x[i]) lowest = 4'(i);
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '0;
      for (int i = 0; i < 5; i++) cap[i] <= '0;
    end else begin
      st_q <= v & ~rdy;
      for (int i = 0; i < 5; i++) cap[i] <= pl[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= '0;
      w_cnt  <= '0;
      rd_cnt <= '0;
      wt     <= '0;
      rt     <= '0;
    end else begin
      aw_cnt <= aw_cnt + 4'(aw_hs & !aw_ovf) - 4'(b_dec);
      w_cnt  <= w_cnt + 4'(w_hs & !w_ovf) - 4'(b_dec);
      rd_cnt <= rd_cnt + 4'(ar_hs & !ar_ovf) - 4'(r_dec);
      wt     <= (b_hs | aw_cnt == 4'd0) ? '0 : wt != TMAX ? wt + 1'b1 : wt;
      rt     <= (r_hs | rd_cnt == 4'd0) ? '0 : rt != TMAX ? rt + 1'b1 : rt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flags <= '0;
      first_err <= '0;
    end else begin
      err_flags <= (err_clear ? 16'd0 : err_flags) | viol;
      first_err <= ((err_clear | err_flags == 16'd0) & |viol) ? lowest(viol) :
                   err_clear ? 4'd0 : first_err;
    end
  end
  assign err_any  = |err_flags;
  assign wr_outst = aw_cnt;
  assign rd_outst = rd_cnt;
endmodule

// File: tb/tb_axi_lite_protocol_monitor.sv
// tb_axi_lite_protocol_monitor: directed scenario tests of the AXI-Lite monitor
module tb_axi_lite_protocol_monitor;
  logic clk = 0, rst = 1;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, err_clear;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [2:0] aw_prot, ar_prot;
  logic [3:0] w_strb;
  logic [1:0] b_resp, r_resp;
  logic [15:0] err_flags;
  logic err_any;
  logic [3:0] first_err, wr_outst, rd_outst;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  axi_lite_protocol_monitor #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_prot(aw_prot),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .err_clear(err_clear), .err_flags(err_flags), .err_any(err_any),
    .first_err(first_err), .wr_outst(wr_outst), .rd_outst(rd_outst)
  );
  task automatic idle();
    {aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready} = '0;
    {ar_valid, ar_ready, r_valid, r_ready, err_clear} = '0;
    {aw_addr, w_data, ar_addr, r_data} = '0;
    {aw_prot, ar_prot, w_strb, b_resp, r_resp} = '0;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step(2);
    rst = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 1;
    step(2);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0000", err_flags); end
    total++; if (err_any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", err_any); end
    total++; if (first_err !== 4'd0) begin bad++; $display("FAIL reset_first got=%0d exp=0", first_err); end
    total++; if (wr_outst !== 4'd0) begin bad++; $display("FAIL reset_wr got=%0d exp=0", wr_outst); end
    total++; if (rd_outst !== 4'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd_outst); end
    rst = 0;
  endtask
  task automatic test_aw_stall();
    do_reset();
    aw_valid = 1; aw_addr = 32'h100;
    step(3);
    total++; if (wr_outst !== 4'd0) begin bad++; $display("FAIL aw_stall_wr got=%0d exp=0", wr_outst); end
    aw_ready = 1;
    step(1);
    aw_valid = 0; aw_ready = 0;
    total++; if (wr_outst !== 4'd1) begin bad++; $display("FAIL aw_hs_wr got=%0d exp=1", wr_outst); end
    step(1);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL aw_stall_flags got=%h exp=0000", err_flags); end
  endtask
  task automatic test_valid_drop();
    do_reset();
    aw_valid = 1; aw_addr = 32'h200;
    step(1);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL drop_pre got=%h exp=0000", err_flags); end
    aw_valid = 0;
    step(1);
    total++; if (err_flags !== 16'h0001) begin bad++; $display("FAIL drop_flags got=%h exp=0001", err_flags); end
    total++; if (first_err !== 4'd0) begin bad++; $display("FAIL drop_first got=%0d exp=0", first_err); end
    total++; if (err_any !== 1'b1) begin bad++; $display("FAIL drop_any got=%b exp=1", err_any); end
  endtask
  task automatic test_payload_change();
    do_reset();
    ar_valid = 1; ar_addr = 32'h40;
    step(1);
    ar_addr = 32'h44;
    step(1);
    total++; if (err_flags !== 16'h0080) begin bad++; $display("FAIL chg_flags got=%h exp=0080", err_flags); end
    total++; if (first_err !== 4'd7) begin bad++; $display("FAIL chg_first got=%0d exp=7", first_err); end
    err_clear = 1;
    step(1);
    err_clear = 0;
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL clr_flags got=%h exp=0000", err_flags); end
    total++; if (first_err !== 4'd0) begin bad++; $display("FAIL clr_first got=%0d exp=0", first_err); end
    ar_addr = 32'h48; err_clear = 1;
    step(1);
    err_clear = 0;
    total++; if (err_flags !== 16'h0080) begin bad++; $display("FAIL set_wins got=%h exp=0080", err_flags); end
    total++; if (first_err !== 4'd7) begin bad++; $display("FAIL set_wins_first got=%0d exp=7", first_err); end
    ar_ready = 1;
    step(1);
    ar_valid = 0; ar_ready = 0;
    total++; if (rd_outst !== 4'd1) begin bad++; $display("FAIL ar_hs_rd got=%0d exp=1", rd_outst); end
  endtask
  task automatic test_b_no_req();
    do_reset();
    b_valid = 1; b_ready = 1;
    step(1);
    b_valid = 0; b_ready = 0;
    total++; if (err_flags !== 16'h0400) begin bad++; $display("FAIL b_noreq_flags got=%h exp=0400", err_flags); end
    total++; if (first_err !== 4'd10) begin bad++; $display("FAIL b_noreq_first got=%0d exp=10", first_err); end
    total++; if (wr_outst !== 4'd0) begin bad++; $display("FAIL b_noreq_wr got=%0d exp=0", wr_outst); end
  endtask
  task automatic test_r_no_req();
    do_reset();
    r_valid = 1; r_ready = 1;
    step(1);
    r_valid = 0; r_ready = 0;
    total++; if (err_flags !== 16'h0800) begin bad++; $display("FAIL r_noreq_flags got=%h exp=0800", err_flags); end
    total++; if (rd_outst !== 4'd0) begin bad++; $display("FAIL r_noreq_rd got=%0d exp=0", rd_outst); end
  endtask
  task automatic test_rd_overflow();
    do_reset();
    ar_valid = 1; ar_ready = 1; ar_addr = 32'h80;
    step(4);
    total++; if (rd_outst !== 4'd4) begin bad++; $display("FAIL ovf4_rd got=%0d exp=4", rd_outst); end
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL ovf4_flags got=%h exp=0000", err_flags); end
    step(1);
    ar_valid = 0; ar_ready = 0;
    total++; if (rd_outst !== 4'd4) begin bad++; $display("FAIL ovf5_rd got=%0d exp=4", rd_outst); end
    total++; if (err_flags !== 16'h2000) begin bad++; $display("FAIL ovf5_flags got=%h exp=2000", err_flags); end
    total++; if (first_err !== 4'd13) begin bad++; $display("FAIL ovf5_first got=%0d exp=13", first_err); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    aw_valid = 1; aw_ready = 1; w_valid = 1; w_ready = 1;
    step(1);
    total++; if (wr_outst !== 4'd1) begin bad++; $display("FAIL b2b_first_wr got=%0d exp=1", wr_outst); end
    b_valid = 1; b_ready = 1; aw_addr = 32'h4; w_data = 32'h55;
    step(1);
    total++; if (wr_outst !== 4'd1) begin bad++; $display("FAIL b2b_net0_wr got=%0d exp=1", wr_outst); end
    aw_valid = 0; w_valid = 0;
    step(1);
    b_valid = 0; b_ready = 0;
    total++; if (wr_outst !== 4'd0) begin bad++; $display("FAIL b2b_drain_wr got=%0d exp=0", wr_outst); end
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL b2b_flags got=%h exp=0000", err_flags); end
  endtask
  task automatic test_timeout();
    do_reset();
    aw_valid = 1; aw_ready = 1; w_valid = 1; w_ready = 1;
    step(1);
    idle();
    step(7);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL to_early got=%h exp=0000", err_flags); end
    step(1);
    total++; if (err_flags !== 16'h4000) begin bad++; $display("FAIL to_flags got=%h exp=4000", err_flags); end
    total++; if (first_err !== 4'd14) begin bad++; $display("FAIL to_first got=%0d exp=14", first_err); end
    err_clear = 1;
    step(1);
    err_clear = 0;
    step(3);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL to_once got=%h exp=0000", err_flags); end
    b_valid = 1; b_ready = 1;
    step(1);
    b_valid = 0; b_ready = 0;
    total++; if (wr_outst !== 4'd0) begin bad++; $display("FAIL to_b_wr got=%0d exp=0", wr_outst); end
    aw_valid = 1; aw_ready = 1; w_valid = 1; w_ready = 1;
    step(1);
    idle();
    step(7);
    total++; if (err_flags !== 16'h0) begin bad++; $display("FAIL to_restart_early got=%h exp=0000", err_flags); end
    step(1);
    total++; if (err_flags !== 16'h4000) begin bad++; $display("FAIL to_restart got=%h exp=4000", err_flags); end
  endtask
  initial begin
    idle();
    test_reset();
    test_aw_stall();
    test_valid_drop();
    test_payload_change();
    test_b_no_req();
    test_r_no_req();
    test_rd_overflow();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
